bench_cmd_scheduler: RTL and testbench

Sits between the AXI-Lite benchmark register block and the NUM_CH memory benchmark engines (DDR channels). It accepts packed 193-bit bench commands with a destination field and dispatches each to its target channel engine. It tracks each channel's busy state, measures per-channel execution cycles, and counts completed runs. Status is exposed for readback through the register block.

---
 rtl/bench_cmd_scheduler.sv | 124 ++++++++++++
 tb/tb_bench_cmd_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bench_cmd_scheduler.sv
// bench_cmd_scheduler: one-entry command hold + dispatch to per-channel bench engines with busy/cycle/run tracking
// BENCH_SCHED_TIMEOUT_EN enables the per-channel watchdog (ch_timeout)
module bench_cmd_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CMD_W = 193,
  parameter int CNT_W = 64,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic                    user_clk,
  input  logic                    user_reset,
  input  logic                    s_axis_cmd_valid,
  output logic                    s_axis_cmd_ready,
  input  logic [CMD_W-1:0]        s_axis_cmd_data,
  input  logic [1:0]              s_axis_cmd_dest,
  output logic [NUM_CH-1:0]       m_axis_ch_cmd_valid,
  input  logic [NUM_CH-1:0]       m_axis_ch_cmd_ready,
  output logic [CMD_W-1:0]        m_axis_ch_cmd_data,
  input  logic [NUM_CH-1:0]       ch_done,
  output logic [NUM_CH-1:0]       ch_busy,
  output logic [NUM_CH*CNT_W-1:0] ch_exec_cycles,
  output logic [NUM_CH*32-1:0]    ch_cmd_count,
  output logic                    err_bad_dest,
  output logic [NUM_CH-1:0]       ch_timeout
);
  typedef enum logic {D_IDLE, D_ISSUE} d_state_t;
  d_state_t state, state_n;
  logic hold_valid, hold_valid_n, cmd_ready, accept, clear_hold, set_err;
  logic [1:0] hold_dest;
  logic [CMD_W-1:0] hold_data;
  logic [NUM_CH-1:0] sel, hs, busy, valid_n;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt;
  logic [NUM_CH-1:0][31:0] runs;
  assign s_axis_cmd_ready = cmd_ready;
  assign accept = s_axis_cmd_valid & cmd_ready;
  assign hold_valid_n = accept | (hold_valid & ~clear_hold);
  assign hs = m_axis_ch_cmd_valid & m_axis_ch_cmd_ready;
  assign m_axis_ch_cmd_data = hold_data;
  assign ch_busy = busy;
  assign ch_exec_cycles = cnt;
  assign ch_cmd_count = runs;
  always_comb begin
    state_n = state;
    valid_n = m_axis_ch_cmd_valid;
    clear_hold = 1'b0;
    set_err = 1'b0;
    if (state == D_ISSUE) begin
      if (|hs) begin
        valid_n = '0;
        clear_hold = 1'b1;
        state_n = D_IDLE;
      end
    end else if (hold_valid) begin
      if (~|sel) begin
        clear_hold = 1'b1;
        set_err = 1'b1;
      end else if (|(sel & ~busy)) begin
        valid_n = sel;
        state_n = D_ISSUE;
      end
    end
  end
  // ready is held low for the cycle after a capture and the cycle after a release
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state <= D_IDLE;
      hold_valid <= 1'b0;
      hold_dest <= '0;
      hold_data <= '0;
      cmd_ready <= 1'b0;
      m_axis_ch_cmd_valid <= '0;
      err_bad_dest <= 1'b0;
    end else begin
      state <= state_n;
      hold_valid <= hold_valid_n;
      if (accept) begin
        hold_dest <= s_axis_cmd_dest;
        hold_data <= s_axis_cmd_data;
      end
      cmd_ready <= ~hold_valid & ~hold_valid_n;
      m_axis_ch_cmd_valid <= valid_n;
      err_bad_dest <= err_bad_dest | set_err;
    end
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic b, expire;
    logic [CNT_W-1:0] c, inc;
    logic [31:0] r;
    assign sel[i] = hold_valid && hold_dest == 2'(i);
    assign inc = &c ? c : c + 1'b1;
    assign busy[i] = b;
    assign cnt[i] = c;
    assign runs[i] = r;
`ifdef BENCH_SCHED_TIMEOUT_EN
    logic t;
    assign expire = b & ~ch_done[i] & (inc == CNT_W'(TIMEOUT_CYCLES));
    assign ch_timeout[i] = t;
    always_ff @(posedge user_clk) begin
      if (user_reset) t <= 1'b0;
      else if (expire) t <= 1'b1;
    end
`else
    assign expire = 1'b0;
`endif
    always_ff @(posedge user_clk) begin
      if (user_reset) begin
        b <= 1'b0;
        c <= '0;
        r <= '0;
      end else if (hs[i]) begin
        b <= 1'b1;
        c <= '0;
      end else if (b) begin
        c <= inc;
        if (ch_done[i]) begin
          b <= 1'b0;
          r <= r + 1'b1;
        end else if (expire) b <= 1'b0;
      end
    end
  end
`ifndef BENCH_SCHED_TIMEOUT_EN
  assign ch_timeout = {NUM_CH{TIMEOUT_CYCLES < 0}};
`endif
endmodule

// File: tb/tb_bench_cmd_scheduler.sv
// tb_bench_cmd_scheduler: randomized bench for bench_cmd_scheduler against a cycle-count reference model
module tb_bench_cmd_scheduler;
  localparam int N = 4, W = 193, TO = 50, INF = 32'h7fffffff;
  typedef struct {logic [1:0] dest; logic [W-1:0] data;} cmd_t;
  logic user_clk = 1'b0, user_reset;
  always #5 user_clk = ~user_clk;
  logic s_valid, s_ready, err;
  logic [W-1:0] s_data, m_data;
  logic [1:0] s_dest;
  logic [N-1:0] m_valid, m_ready, ch_done, ch_busy, ch_timeout;
  logic [N*64-1:0] ch_exec;
  logic [N*32-1:0] ch_count;
  logic v3, r3, err3;
  logic [W-1:0] data3, md3;
  logic [1:0] dst3;
  logic [2:0] mv3, busy3, to3;
  logic [191:0] exec3;
  logic [95:0] cnt3;
  bench_cmd_scheduler #(.NUM_CH(N), .TIMEOUT_CYCLES(TO)) u_dut (
    .user_clk(user_clk), .user_reset(user_reset),
    .s_axis_cmd_valid(s_valid), .s_axis_cmd_ready(s_ready), .s_axis_cmd_data(s_data), .s_axis_cmd_dest(s_dest),
    .m_axis_ch_cmd_valid(m_valid), .m_axis_ch_cmd_ready(m_ready), .m_axis_ch_cmd_data(m_data),
    .ch_done(ch_done), .ch_busy(ch_busy), .ch_exec_cycles(ch_exec), .ch_cmd_count(ch_count),
    .err_bad_dest(err), .ch_timeout(ch_timeout));
  bench_cmd_scheduler #(.NUM_CH(3), .TIMEOUT_CYCLES(TO)) u_dut3 (
    .user_clk(user_clk), .user_reset(user_reset),
    .s_axis_cmd_valid(v3), .s_axis_cmd_ready(r3), .s_axis_cmd_data(data3), .s_axis_cmd_dest(dst3),
    .m_axis_ch_cmd_valid(mv3), .m_axis_ch_cmd_ready(3'b111), .m_axis_ch_cmd_data(md3),
    .ch_done(3'b000), .ch_busy(busy3), .ch_exec_cycles(exec3), .ch_cmd_count(cnt3),
    .err_bad_dest(err3), .ch_timeout(to3));

  int n_tests = 0, n_fail = 0;
  int cyc = 0, acc_cyc = 0, rise_cyc = 0;
  int mstart[N], hs_cyc[N], done_cyc[N], done_due[N], lat[N], rdy_hold[N];
  logic [N-1:0] mbusy, mto, force_done;
  logic [63:0] mexec[N];
  logic [31:0] mcnt[N];
  bit rnd, hold_full;
  cmd_t src_q[$], exp_q[$];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] rnd_data();
    logic [223:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return w[W-1:0];
  endfunction

  task automatic push(input logic [1:0] d);
    cmd_t c;
    c.dest = d;
    c.data = rnd_data();
    src_q.push_back(c);
  endtask

  // one clock: note pending events, advance the model at the edge, drive the engines, then compare
  task automatic step();
    logic [N-1:0] hs, de, pv;
    logic [W-1:0] pd;
    logic acc;
    cmd_t c;
    hs = m_valid & m_ready;
    acc = s_valid & s_ready;
    de = ch_done & mbusy;
    pv = m_valid;
    pd = m_data;
    if (hs != 0) begin
      if (exp_q.size() == 0) check("hs_spurious", hs, 0);
      else begin
        c = exp_q.pop_front();
        check("hs_dest", hs, 4'b1 << c.dest);
        check("hs_data", m_data, c.data);
        check("hs_idle", mbusy & hs, 0);
        hold_full = 0;
      end
    end
    @(posedge user_clk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (de[i]) begin
        mbusy[i] = 0; mexec[i] = 64'(cyc - mstart[i]); mcnt[i]++; done_cyc[i] = cyc; done_due[i] = INF;
      end
`ifdef BENCH_SCHED_TIMEOUT_EN
      else if (mbusy[i] && cyc - mstart[i] == TO) begin
        mbusy[i] = 0; mexec[i] = 64'(TO); mto[i] = 1; done_due[i] = INF;
      end
`endif
      if (hs[i]) begin
        mbusy[i] = 1; mstart[i] = cyc; hs_cyc[i] = cyc;
        done_due[i] = rnd ? cyc + int'($urandom_range(1, 40)) : (lat[i] == 0 ? INF : cyc + lat[i]);
      end
    end
    if (acc) begin
      exp_q.push_back(src_q.pop_front());
      acc_cyc = cyc;
      hold_full = 1;
    end
    #1;
    if (m_valid != 0 && pv == 0) rise_cyc = cyc;
    s_valid = src_q.size() > 0;
    if (s_valid) begin
      s_dest = src_q[0].dest;
      s_data = src_q[0].data;
    end
    for (int i = 0; i < N; i++) begin
      if (m_valid[i] && rdy_hold[i] > 0) begin
        m_ready[i] = 0; rdy_hold[i]--;
      end else m_ready[i] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      ch_done[i] = (cyc + 1 == done_due[i]) | force_done[i] | (rnd && !mbusy[i] && $urandom_range(0, 19) == 0);
    end
    force_done = '0;
    @(negedge user_clk);
    check("valid_onehot", $onehot0(m_valid), 1);
    if (pv != 0 && hs == 0) begin
      check("valid_stable", m_valid, pv);
      check("data_stable", m_data, pd);
    end
    check("sready_hold", s_ready & hold_full, 0);
    check("busy", ch_busy, mbusy);
    check("timeout", ch_timeout, mto);
    check("err", err, 0);
    for (int i = 0; i < N; i++) begin
      check("exec", ch_exec[i*64 +: 64], mbusy[i] ? 64'(cyc - mstart[i]) : mexec[i]);
      check("count", ch_count[i*32 +: 32], mcnt[i]);
    end
  endtask

  task automatic do_reset();
    user_reset = 1; s_valid = 0; s_data = '0; s_dest = '0; m_ready = '0; ch_done = '0;
    v3 = 0; data3 = '0; dst3 = '0;
    repeat (2) @(posedge user_clk);
    @(negedge user_clk);
    check("rst_sready", s_ready, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_busy", ch_busy, 0);
    check("rst_exec", ch_exec, 0);
    check("rst_count", ch_count, 0);
    check("rst_err", err, 0);
    check("rst_timeout", ch_timeout, 0);
    check("rst_u3", {r3, mv3, md3, busy3, exec3, cnt3, err3, to3}, 0);
    mbusy = '0; mto = '0; force_done = '0; hold_full = 0; rnd = 0;
    src_q.delete(); exp_q.delete();
    for (int i = 0; i < N; i++) begin
      mexec[i] = '0; mcnt[i] = '0; done_due[i] = INF; lat[i] = 0; rdy_hold[i] = 0;
    end
    user_reset = 0;
    @(negedge user_clk);
  endtask

  task automatic send3(input logic [1:0] d, input logic [W-1:0] x);
    int t;
    t = 0; v3 = 1; dst3 = d; data3 = x;
    while (!r3 && t < 20) begin
      @(negedge user_clk);
      t++;
    end
    check("u3_accept", r3, 1);
    @(posedge user_clk);
    #1 v3 = 0;
    @(negedge user_clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] x;
    logic [31:0] prev[N];
    logic [63:0] ex[N];
    logic [31:0] c0;
    int d1;
    do_reset();
    // three-channel instance: dest 3 is discarded, a following dest 0 goes through
    send3(2'd3, rnd_data());
    for (int t = 0; t < 6; t++) begin
      check("u3_bad_valid", mv3, 0);
      @(negedge user_clk);
    end
    check("u3_err", err3, 1);
    x = rnd_data();
    send3(2'd0, x);
    for (int t = 0; t < 10 && mv3 == 0; t++) @(negedge user_clk);
    check("u3_valid", mv3, 3'b001);
    check("u3_data", md3, x);
    @(negedge user_clk);
    check("u3_busy", busy3, 3'b001);
    do_reset();
    // single run on channel 1, done 100 cycles after the handshake
    lat[1] = 100;
    push(2'd1);
    for (int t = 0; t < 300 && mcnt[1] != 1; t++) step();
    check("t1_done", mcnt[1], 1);
    check("t1_latency", rise_cyc - acc_cyc, 1);
    check("t1_valid_len", hs_cyc[1] - rise_cyc, 1);
    check("t1_exec", ch_exec[64 +: 64], 100);
    check("t1_count", ch_count[32 +: 32], 1);
    // channel 2 engine holds ready low for five cycles
    lat[2] = 10; rdy_hold[2] = 5;
    push(2'd2);
    for (int t = 0; t < 50 && !mbusy[2]; t++) begin
      step();
      if (hold_full) check("t2_sready", s_ready, 0);
    end
    check("t2_hs_delay", hs_cyc[2] - rise_cyc, 6);
    for (int t = 0; t < 50 && mcnt[2] != 1; t++) step();
    check("t2_count", ch_count[64 +: 32], 1);
    // back-to-back commands to channel 0: second waits for done
    lat[0] = 20;
    push(2'd0);
    push(2'd0);
    for (int t = 0; t < 200 && mcnt[0] != 1; t++) step();
    d1 = done_cyc[0];
    for (int t = 0; t < 20 && !mbusy[0]; t++) step();
    check("t3_redispatch", rise_cyc - d1, 1);
    for (int t = 0; t < 200 && mcnt[0] != 2; t++) step();
    check("t3_count", ch_count[31:0], 2);
    check("t3_exec", ch_exec[63:0], 20);
    // all four channels busy, simultaneous done, then stray dones while idle
    for (int i = 0; i < N; i++) begin
      lat[i] = 0; prev[i] = mcnt[i]; push(2'(i));
    end
    for (int t = 0; t < 100 && mbusy != 4'hf; t++) step();
    check("t5_all_busy", ch_busy, 4'hf);
    repeat (5) step();
    force_done = 4'hf;
    step();
    step();
    check("t5_busy_drop", ch_busy, 0);
    for (int i = 0; i < N; i++) begin
      check("t5_exec", ch_exec[i*64 +: 64], 64'(cyc - hs_cyc[i]));
      check("t5_count", ch_count[i*32 +: 32], prev[i] + 1);
      ex[i] = 64'(cyc - hs_cyc[i]);
    end
    force_done = 4'hf;
    repeat (3) step();
    for (int i = 0; i < N; i++) begin
      check("t5_stray_count", ch_count[i*32 +: 32], prev[i] + 1);
      check("t5_stray_exec", ch_exec[i*64 +: 64], ex[i]);
    end
    // randomized traffic, ready stalls and stray dones
    rnd = 1;
    for (int k = 0; k < 3000; k++) begin
      if (src_q.size() < 2 && $urandom_range(0, 1) == 1) push(2'($urandom_range(0, 3)));
      step();
    end
    rnd = 0;
    for (int i = 0; i < N; i++) lat[i] = 10;
    for (int t = 0; t < 500 && (src_q.size() != 0 || exp_q.size() != 0 || mbusy != 0); t++) step();
    check("drain", {src_q.size() != 0, exp_q.size() != 0, mbusy}, 0);
`ifdef BENCH_SCHED_TIMEOUT_EN
    lat[3] = 0;
    c0 = mcnt[3];
    push(2'd3);
    for (int t = 0; t < 200 && !mto[3]; t++) step();
    check("t6_timeout", ch_timeout[3], 1);
    check("t6_busy", ch_busy[3], 0);
    check("t6_count", ch_count[96 +: 32], c0);
    check("t6_exec", ch_exec[192 +: 64], TO);
`else
    c0 = mcnt[3];
    check("t6_count_nto", ch_count[96 +: 32], c0);
`endif
    // reset in the middle of a run
    lat[1] = 0;
    push(2'd1);
    for (int t = 0; t < 50 && !mbusy[1]; t++) step();
    check("t7_running", ch_busy[1], 1);
    repeat (3) step();
    do_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
